// File: rtl/imem_pkg.sv
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared FSM encodings, fault codes and sizing helper for imem_loadable
// Revision : 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;

  function automatic int nb_of(input int instr_w);
    return instr_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_ram.sv
// ============================================================================
// Module   : byte_ram
// Purpose  : DEPTH x 8 store, one synchronous write port, NB combinational read taps
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_ram #(
  parameter int DEPTH = 256,
  parameter int NB    = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [NB*8-1:0]   rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Tap 0 lands in the most significant byte (big-endian word assembly).
  for (genvar i = 0; i < NB; i++) begin : g_tap
    assign rd_data[(NB-1-i)*8 +: 8] = mem[rd_addr + PTR_W'(i)];
  end

endmodule

`default_nettype wire

// File: rtl/imem_loadable.sv
// ============================================================================
// Module   : imem_loadable
// Purpose  : Self-clearing, stream-loadable byte instruction memory with registered fetch
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loadable
  import imem_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [7:0]         load_data,
  input  logic               load_valid,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_done,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ready,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               fetch_fault
);

  localparam int NB    = nb_of(INSTR_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int EXT_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(DEPTH - 1);
  localparam logic [EXT_W-1:0] ADDR_LIM  = EXT_W'(DEPTH - NB);
  localparam logic [EXT_W-1:0] NB_EXT    = EXT_W'(NB);

  logic [1:0]         r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_load_done;
  logic               r_fetch_valid;
  logic [INSTR_W-1:0] r_instruction;
  logic               r_fetch_fault;

  logic               w_load_acc;
  logic               w_fetch_acc;
  logic               w_load_end;
  logic [EXT_W-1:0]   w_addr_ext;
  logic               w_misaligned;
  logic               w_out_of_range;
  logic [1:0]         w_fault_code;
  logic               w_fault;
  logic               w_we;
  logic [7:0]         w_wr_data;
  logic [INSTR_W-1:0] w_rd_data;

  assign load_ready  = (r_state == ST_LOAD);
  assign fetch_ready = (r_state == ST_RUN);
  assign load_done   = r_load_done;
  assign fetch_valid = r_fetch_valid;
  assign instruction = r_instruction;
  assign fetch_fault = r_fetch_fault;

  assign w_load_acc  = load_valid && load_ready;
  assign w_fetch_acc = fetch_req && fetch_ready;
  assign w_load_end  = load_last || (r_ptr == PTR_MAX);

  // Range check at ADDR_W+1 bits so a large address can never wrap into range.
  assign w_addr_ext     = {1'b0, fetch_addr};
  assign w_misaligned   = (w_addr_ext % NB_EXT) != '0;
  assign w_out_of_range = w_addr_ext > ADDR_LIM;
  assign w_fault_code   = w_misaligned   ? FAULT_MISALIGN :
                          w_out_of_range ? FAULT_RANGE    : FAULT_NONE;
  assign w_fault        = (w_fault_code != FAULT_NONE);

  assign w_we      = !rst && ((r_state == ST_CLEAR) || w_load_acc);
  assign w_wr_data = (r_state == ST_LOAD) ? load_data : 8'h00;

  byte_ram #(
    .DEPTH (DEPTH),
    .NB    (NB),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_we),
    .wr_addr (r_ptr),
    .wr_data (w_wr_data),
    .rd_addr (fetch_addr[PTR_W-1:0]),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_CLEAR;
      r_ptr         <= '0;
      r_load_done   <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_instruction <= '0;
      r_fetch_fault <= 1'b0;
    end else begin
      r_load_done   <= 1'b0;
      r_fetch_valid <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_ptr == PTR_MAX) begin
            r_state <= ST_RUN;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + PTR_W'(1);
          end
        end
        ST_LOAD: begin
          if (w_load_acc) begin
            if (w_load_end) begin
              r_state     <= ST_RUN;
              r_load_done <= 1'b1;
              r_ptr       <= '0;
            end else begin
              r_ptr <= r_ptr + PTR_W'(1);
            end
          end
        end
        ST_RUN: begin
          // A fetch coinciding with load_start is still served this cycle.
          if (w_fetch_acc) begin
            r_fetch_valid <= 1'b1;
            r_fetch_fault <= w_fault;
            r_instruction <= w_fault ? '0 : w_rd_data;
          end
          if (load_start) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, loadable successor to the combinational 16-bit instruction memory: a byte-organised instruction store with a registered fetch port and a streaming program-load port. It sits between the PC/fetch stage and the test harness or boot loader of the MIPS core. It clears itself after reset, accepts a program as a byte stream, then serves aligned, big-endian instruction fetches with one-cycle latency and an explicit fault flag.

## Interface
- `INSTR_W`, 16: instruction width in bits; multiple of 8, at least 16. NB = INSTR_W/8 bytes per instruction.
- `ADDR_W`, 16: byte-address width of `fetch_addr`.
- `DEPTH`, 256: memory size in bytes; multiple of NB, power of two, at most 2^ADDR_W.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_start`  in  1  one-cycle pulse that begins a program load; honoured only in RUN.
- `load_data`  in  8  program byte.
- `load_valid`  in  1  `load_data` is valid.
- `load_last`  in  1  qualifies the final byte of the stream.
- `load_ready`  out  1  block accepts a byte this cycle; high only in LOAD.
- `load_done`  out  1  one-cycle pulse when a load completes.
- `fetch_req`  in  1  fetch request, sampled when `fetch_ready` is high.
- `fetch_addr`  in  ADDR_W  byte address of the instruction.
- `fetch_ready`  out  1  high only in RUN.
- `fetch_valid`  out  1  `instruction` and `fetch_fault` are valid.
- `instruction`  out  INSTR_W  fetched word; big-endian, so mem[a] lands in the MSB.
- `fetch_fault`  out  1  the fetch was misaligned or out of range.

## Operation
- There are three states: CLEAR, LOAD and RUN.
- **CLEAR** is entered on `rst`.
  - A byte counter sweeps addresses 0..DEPTH-1 and writes 0x00, one byte per cycle.
  - After address DEPTH-1 is written, the next state is RUN.
- **RUN**:
  - `fetch_req` causes a read at `fetch_addr`.
  - A fetch faults if `fetch_addr % NB != 0` or if `fetch_addr > DEPTH-NB`. A faulting fetch returns `instruction` = 0 and `fetch_fault` = 1, and the memory is not read.
  - `load_start` moves the block to LOAD and sets the write pointer to 0.
  - If `load_start` and `fetch_req` are high in the same cycle, the fetch is still served and the state changes afterwards.
- **LOAD**:
  - `load_ready` = 1.
  - Each cycle with `load_valid && load_ready` writes `load_data` to mem[ptr] and increments ptr.
  - An accepted byte with `load_last`, or an accepted write at ptr = DEPTH-1, completes the load: `load_done` pulses and the next state is RUN.
  - Bytes above the final pointer keep their previous contents. The load does not re-clear memory.
  - `fetch_req` is ignored, `fetch_ready` = 0 and `fetch_valid` stays 0.
- `rst` in any state, including mid-LOAD, aborts the current activity and restarts CLEAR. Partially loaded bytes are wiped.
- Address arithmetic:
  - Byte i of an instruction is read from mem[fetch_addr + i], with i = 0 as the MSB.
  - The comparison is done at ADDR_W+1 bits so that no wrap-around can alias an address into range.

## Timing
- Reset values:
  - state = CLEAR, ptr = 0.
  - `load_ready` = 0, `load_done` = 0, `fetch_ready` = 0, `fetch_valid` = 0.
  - `instruction` = 0, `fetch_fault` = 0.
- CLEAR lasts exactly DEPTH cycles after `rst` deasserts. `fetch_ready` rises in cycle DEPTH (counting from 0).
- Fetch latency is one cycle: a request at edge N gives `fetch_valid`, `instruction` and `fetch_fault` after edge N+1.
- `fetch_valid` is high for one cycle per accepted request. Back-to-back requests give one result per cycle.
- Outputs hold their last value while `fetch_valid` = 0. `fetch_fault` is meaningful only with `fetch_valid`.
- Load throughput is one byte per cycle, and gaps in `load_valid` are allowed.
- `load_done` is asserted in the cycle after the final accepted byte, and `fetch_ready` = 1 in that same cycle.
- Write-then-read ordering: a byte written at edge N is visible to a fetch sampled at edge N+1 or later.

## Structure
- A shared package `imem_pkg` holds:
  - the state enum {CLEAR, LOAD, RUN};
  - the function `nb_of(INSTR_W)`;
  - the fault-code constants reused by the fetch stage.
- Storage is a sub-module `byte_ram`: DEPTH×8, with one synchronous write port and NB combinational read taps. The controller and FSM live in `imem_loadable`.

## Test plan
- **Reset then idle:** `rst` for 2 cycles, then release. `fetch_ready` is 0 for 256 cycles, then 1. A fetch at addr 0x0000 gives `instruction` = 0x0000 and `fetch_fault` = 0.
- **Load and fetch:** stream 0xE1, 0x88, 0x0C, 0x70 with `load_last` on the 4th byte. Then:
  - `load_done` pulses once;
  - a fetch at 0x0000 gives 0xE188;
  - a fetch at 0x0002 gives 0x0C70;
  - a fetch at 0x0004 gives 0x0000.
- **Faults:** a fetch at 0x0003 gives fault = 1 and `instruction` = 0. A fetch at 0x00FF gives fault = 1. A fetch at 0x00FE gives fault = 0. A fetch at 0xFFFE gives fault = 1, with no wrap.
- **Handshake gaps:** `load_valid` toggles 1,0,0,1,1. Only the 3 accepted bytes are written, at addresses 0..2. `fetch_req` during LOAD produces no `fetch_valid`.
- **Full-depth load:** 256 bytes with no `load_last`. `load_done` pulses after byte 255, and a fetch at 0x00FE returns bytes 254 and 255.
- **Reset mid-load:** assert `rst` after 10 bytes. After CLEAR, a fetch at 0x0000 returns 0x0000. Also check a `load_start` that coincides with a fetch: that fetch is still served.
